// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// field sizes of the byte-serial image format.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_CNT  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Big-endian byte-to-word assembler; w_word includes the byte accepted on the
// current edge, so the consumer can act on the same edge that takes byte 4.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;  // wraps 3->0 so fields line up back to back
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a byte-serial program image (addr, count, payload) into imem and
// holds the core until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int MAX_WORDS  = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic [31:0] o_start_pc,
  output logic        o_load_done,
  output logic        o_load_err,
  output logic        o_cpu_hold
);
  state_t      r_state;
  logic [31:0] r_addr, r_cnt, r_idx;
  logic        r_in_ready, r_we, r_done, r_err, r_hold;
  logic [31:0] r_waddr, r_wdata, r_start_pc;

  logic        w_fire, w_word_valid;
  logic [31:0] w_word;
  logic [32:0] w_end;
  logic        w_bad;

  assign w_fire = i_in_valid && r_in_ready;

  byte_to_word_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte_valid (w_fire),
    .i_byte       (i_in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // End word index in 33 bits so a huge count cannot wrap past the check.
  assign w_end = {3'b000, r_addr[31:2]} + {1'b0, w_word};
  assign w_bad = (r_addr[1:0] != 2'b00) || (w_word > 32'(MAX_WORDS)) ||
                 (w_end > 33'(IMEM_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_ADDR;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_start_pc <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hold     <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_ADDR: begin
          r_in_ready <= 1'b1;
          if (w_word_valid) begin
            r_addr  <= w_word;
            r_state <= S_CNT;
          end
        end
        S_CNT: begin
          if (w_word_valid) begin
            r_cnt      <= w_word;
            r_idx      <= '0;
            r_start_pc <= r_addr;
            if (w_bad) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
            end else if (w_word == 32'd0) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_hold     <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_addr + {r_idx[29:0], 2'b00};
            r_wdata <= w_word;
            if (r_idx == r_cnt - 32'd1) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_hold     <= 1'b0;
            end else begin
              r_idx <= r_idx + 32'd1;
            end
          end
        end
        S_DONE: r_in_ready <= 1'b0;
        S_ERR:  r_in_ready <= 1'b0;
        default: begin
          r_state    <= S_ERR;
          r_in_ready <= 1'b0;
          r_err      <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_waddr;
  assign o_imem_wdata = r_wdata;
  assign o_start_pc   = r_start_pc;
  assign o_load_done  = r_done;
  assign o_load_err   = r_err;
  assign o_cpu_hold   = r_hold;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares each imem write.
module tb_imem_loader;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'h00;
  logic        o_in_ready, o_imem_we, o_load_done, o_load_err, o_cpu_hold;
  logic [31:0] o_imem_addr, o_imem_wdata, o_start_pc;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  always #5 i_clk = ~i_clk;

  imem_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_start_pc   (o_start_pc),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err),
    .o_cpu_hold   (o_cpu_hold)
  );

  always @(negedge i_clk) begin
    if (o_imem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 o_imem_addr, o_imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_imem_addr !== e.addr || o_imem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                   o_imem_addr, o_imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      i_in_valid = 1'b0;
      tick();
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    n = 0;
    while (!o_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!o_in_ready) begin
      chk("ready_timeout", {31'd0, o_in_ready}, 32'd1);
    end else begin
      tick();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], stall);
  endtask

  task automatic do_reset();
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    chk("rst_we",       {31'd0, o_imem_we},  32'd0);
    chk("rst_addr",     o_imem_addr,         32'd0);
    chk("rst_wdata",    o_imem_wdata,        32'd0);
    chk("rst_start_pc", o_start_pc,          32'd0);
    chk("rst_done",     {31'd0, o_load_done}, 32'd0);
    chk("rst_err",      {31'd0, o_load_err},  32'd0);
    chk("rst_hold",     {31'd0, o_cpu_hold},  32'd1);
    i_rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, o_in_ready}, 32'd1);
  endtask

  task automatic check_done(input string tag, input logic [31:0] pc);
    chk({tag, "_done"},     {31'd0, o_load_done}, 32'd1);
    chk({tag, "_hold"},     {31'd0, o_cpu_hold},  32'd0);
    chk({tag, "_ready"},    {31'd0, o_in_ready},  32'd0);
    chk({tag, "_err"},      {31'd0, o_load_err},  32'd0);
    chk({tag, "_start_pc"}, o_start_pc,           pc);
  endtask

  task automatic check_err(input string tag);
    chk({tag, "_err"},   {31'd0, o_load_err},  32'd1);
    chk({tag, "_ready"}, {31'd0, o_in_ready},  32'd0);
    chk({tag, "_hold"},  {31'd0, o_cpu_hold},  32'd1);
    chk({tag, "_done"},  {31'd0, o_load_done}, 32'd0);
    // keep offering bytes; the monitor flags any write as unexpected
    i_in_valid = 1'b1;
    i_in_data  = 8'hA5;
    repeat (8) tick();
    i_in_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // 1: nominal load, in_valid held high
    exp_q.push_back('{32'h64, 32'h2008_0004});
    exp_q.push_back('{32'h68, 32'h2009_0008});
    send_word(32'h64, 0);
    send_word(32'd2, 0);
    chk("t1_hold_mid", {31'd0, o_cpu_hold}, 32'd1);
    send_word(32'h2008_0004, 0);
    send_word(32'h2009_0008, 0);
    check_done("t1", 32'd100);

    // 6: post-done traffic with in_valid still high
    i_in_data = 8'h77;
    repeat (6) tick();
    chk("t6_ready", {31'd0, o_in_ready}, 32'd0);
    chk("t6_start_pc", o_start_pc, 32'd100);
    chk("t6_done", {31'd0, o_load_done}, 32'd1);
    i_in_valid = 1'b0;

    // 2: same image with source stalls
    do_reset();
    exp_q.push_back('{32'h64, 32'h2008_0004});
    exp_q.push_back('{32'h68, 32'h2009_0008});
    send_word(32'h64, 1);
    send_word(32'd2, 1);
    send_word(32'h2008_0004, 1);
    send_word(32'h2009_0008, 1);
    check_done("t2", 32'd100);
    i_in_valid = 1'b0;

    // 3a: misaligned address
    do_reset();
    send_word(32'h66, 0);
    send_word(32'd1, 0);
    check_err("t3a");
    chk("t3a_start_pc", o_start_pc, 32'h66);

    // 3b: last word plus one overflows imem
    do_reset();
    send_word(32'h3FC, 0);
    send_word(32'd2, 0);
    check_err("t3b");

    // 3c: count above MAX_WORDS
    do_reset();
    send_word(32'h0, 0);
    send_word(32'd257, 0);
    check_err("t3c");

    // boundary: single word at the last imem slot is legal
    do_reset();
    exp_q.push_back('{32'h3FC, 32'hCAFE_F00D});
    send_word(32'h3FC, 0);
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    check_done("tb", 32'h3FC);
    i_in_valid = 1'b0;

    // 4: empty image
    do_reset();
    send_word(32'h1F4, 0);
    send_word(32'd0, 0);
    check_done("t4", 32'd500);
    i_in_valid = 1'b0;

    // 5: reset after 5 payload bytes, then a fresh image
    do_reset();
    exp_q.push_back('{32'h64, 32'h1111_2222});
    send_word(32'h64, 0);
    send_word(32'd2, 0);
    send_word(32'h1111_2222, 0);
    send_byte(8'h33, 0);
    do_reset();
    exp_q.push_back('{32'h12C, 32'hDEAD_BEEF});
    send_word(32'h12C, 0);
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
    check_done("t5", 32'h12C);
    i_in_valid = 1'b0;

    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end
endmodule
